train_station_checker: RTL and testbench



---
 rtl/train_station_checker.sv | 139 +++++++++++++
 tb/tb_train_station_checker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/train_station_checker.sv
// Streaming checker for stack-station (LIFO siding) permutations.
// Receives a header N followed by N exit-order car numbers. It produces one
// verdict per sequence: whether the order is achievable within STACK_DEPTH,
// whether the input was malformed, and the peak siding occupancy.
module train_station_checker #(
    parameter int MAX_CARS    = 10,
    parameter int STACK_DEPTH = MAX_CARS,
    localparam int DW         = $clog2(MAX_CARS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] data,
    output logic          out_valid,
    output logic          result,
    output logic          err,
    output logic [DW-1:0] peak_depth
);

    localparam logic [DW-1:0] MAXC  = DW'(MAX_CARS);
    localparam int unsigned   DEPTH = STACK_DEPTH;

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     n_q;
    logic [MAX_CARS:1] departed_q;
    logic [DW-1:0]     max_seen_q;
    logic [DW-1:0]     k_q;
    logic [DW-1:0]     cnt_q;
    logic              ok_q;
    logic              err_q;
    logic [DW-1:0]     peak_q;

    logic              header_ok;
    logic              dup;
    logic              bad_elem;
    logic              blocked;
    logic              last_beat;
    logic [DW-1:0]     occupancy;

    // Classify the current header or element against the live siding state.
    always_comb begin
        dup       = 1'b0;
        blocked   = 1'b0;
        header_ok = (data != '0) && (data <= MAXC);
        for (int unsigned i = 1; i <= MAX_CARS; i++) begin
            if (data == DW'(i) && departed_q[i])
                dup = 1'b1;
            // A car still waiting above t means t is not on top of the stack.
            if (DW'(i) > data && DW'(i) <= max_seen_q && !departed_q[i])
                blocked = 1'b1;
        end
        bad_elem  = (data == '0) || (data > n_q) || dup;
        occupancy = data - DW'(1) - k_q;
        last_beat = (cnt_q == n_q - DW'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and verdict outputs; outputs are zero outside OUT.
    always_comb begin
        state_d    = state_q;
        out_valid  = 1'b0;
        result     = 1'b0;
        err        = 1'b0;
        peak_depth = '0;
        case (state_q)
            IDLE: if (in_valid) state_d = header_ok ? RUN : OUT;
            RUN:  if (in_valid && last_beat) state_d = OUT;
            OUT: begin
                state_d    = IDLE;
                out_valid  = 1'b1;
                result     = ok_q & ~err_q;
                err        = err_q;
                peak_depth = peak_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequence bookkeeping: cleared while idle, updated per valid element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= '0;
            departed_q <= '0;
            max_seen_q <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            peak_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    departed_q <= '0;
                    max_seen_q <= '0;
                    k_q        <= '0;
                    cnt_q      <= '0;
                    ok_q       <= 1'b1;
                    peak_q     <= '0;
                    err_q      <= in_valid & ~header_ok;
                    if (in_valid)
                        n_q <= data;
                end
                RUN: if (in_valid) begin
                    cnt_q <= cnt_q + DW'(1);
                    if (bad_elem) begin
                        // Malformed element still counts toward the N beats.
                        err_q <= 1'b1;
                        ok_q  <= 1'b0;
                    end else begin
                        if (data > max_seen_q) begin
                            if (occupancy > peak_q)
                                peak_q <= occupancy;
                            if (32'(occupancy) > DEPTH)
                                ok_q <= 1'b0;
                            max_seen_q <= data;
                        end else if (blocked) begin
                            ok_q <= 1'b0;
                        end
                        for (int unsigned i = 1; i <= MAX_CARS; i++)
                            if (data == DW'(i))
                                departed_q[i] <= 1'b1;
                        k_q <= k_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_train_station_checker.sv
// Directed, table-driven bench for train_station_checker. A default-depth
// instance and a STACK_DEPTH=2 instance see identical stimulus.
module tb_train_station_checker;

    localparam int MAX_CARS = 10;
    localparam int DW       = $clog2(MAX_CARS + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] data;
    logic          out_valid, result, err;
    logic [DW-1:0] peak_depth;
    logic          out_valid2, result2, err2;
    logic [DW-1:0] peak_depth2;

    int tests;
    int fails;

    train_station_checker #(.MAX_CARS(MAX_CARS)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(data),
        .out_valid(out_valid), .result(result), .err(err), .peak_depth(peak_depth)
    );

    train_station_checker #(.MAX_CARS(MAX_CARS), .STACK_DEPTH(2)) u_dut_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(data),
        .out_valid(out_valid2), .result(result2), .err(err2), .peak_depth(peak_depth2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Elements are packed first-in-MSB-nibble.
    typedef struct {
        int          n;
        logic [63:0] el;
        int          stall_at;
        int          stall_len;
        bit          res;
        bit          err;
        int          peak;
        bit          res2;
        bit          hold_out;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int nb;
        int lat;
        nb = (v.n >= 1 && v.n <= MAX_CARS) ? v.n : 0;
        @(negedge clk);
        in_valid = 1'b1;
        data     = DW'(v.n);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i == v.stall_at) begin
                in_valid = 1'b0;
                repeat (v.stall_len) @(negedge clk);
                check({tag, "_stall_quiet"}, int'(out_valid), 0);
                check({tag, "_stall_peak0"}, int'(peak_depth), 0);
            end
            in_valid = 1'b1;
            data     = v.el[63-4*i -: 4];
        end
        @(negedge clk);
        if (v.hold_out) begin
            in_valid = 1'b1;
            data     = DW'(3);
        end else begin
            in_valid = 1'b0;
        end
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 1);
        check({tag, "_result"}, int'(result), int'(v.res));
        check({tag, "_err"}, int'(err), int'(v.err));
        check({tag, "_peak"}, int'(peak_depth), v.peak);
        check({tag, "_d2_result"}, int'(result2), int'(v.res2));
        check({tag, "_d2_err"}, int'(err2), int'(v.err));
        check({tag, "_d2_peak"}, int'(peak_depth2), v.peak);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_single_strobe"}, int'(out_valid), 0);
        check({tag, "_idle_result0"}, int'(result), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        tests = 0;
        fails = 0;
        //          n   elements                stall   res err pk res2 hold
        vecs[0]  = '{5,  64'h3214_5000_0000_0000, -1, 0, 1, 0, 2, 1, 0};
        vecs[1]  = '{3,  64'h3120_0000_0000_0000, -1, 0, 0, 0, 2, 0, 0};
        vecs[2]  = '{4,  64'h4321_0000_0000_0000, -1, 0, 1, 0, 3, 0, 0};
        vecs[3]  = '{10, 64'h1234_5678_9A00_0000,  4, 3, 1, 0, 0, 1, 0};
        vecs[4]  = '{3,  64'h1130_0000_0000_0000, -1, 0, 0, 1, 1, 0, 0};
        vecs[5]  = '{0,  64'h0,                   -1, 0, 0, 1, 0, 0, 0};
        vecs[6]  = '{12, 64'h0,                   -1, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{11, 64'h0,                   -1, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{3,  64'h1420_0000_0000_0000, -1, 0, 0, 1, 0, 0, 0};
        vecs[9]  = '{2,  64'h0100_0000_0000_0000, -1, 0, 0, 1, 0, 0, 0};
        vecs[10] = '{10, 64'hA987_6543_2100_0000, -1, 0, 1, 0, 9, 0, 0};
        vecs[11] = '{2,  64'h2100_0000_0000_0000, -1, 0, 1, 0, 1, 1, 1};
        vecs[12] = '{1,  64'h1000_0000_0000_0000, -1, 0, 1, 0, 0, 1, 0};
        vecs[13] = '{3,  64'h2310_0000_0000_0000, -1, 0, 1, 0, 1, 1, 0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        data     = '0;
        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);
        check("reset_err", int'(err), 0);
        check("reset_peak", int'(peak_depth), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++)
            run_vec(vecs[v], $sformatf("vec%0d", v));

        // Abort mid-sequence: header 4, elements 4,3, then reset.
        @(negedge clk); in_valid = 1'b1; data = DW'(4);
        @(negedge clk); data = DW'(4);
        @(negedge clk); data = DW'(3);
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_peak", int'(peak_depth), 0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midreset_no_stale", int'(out_valid), 0);
        end
        rv = '{2, 64'h2100_0000_0000_0000, -1, 0, 1, 0, 1, 1, 0};
        run_vec(rv, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
